// File: rtl/noc_response_axi_mc_if.sv
`default_nettype none
// noc_response_axi_mc_if -- NoC response, transaction descriptor and AXI R/B bundle (rev 1.0)
interface noc_response_axi_mc_if #(
   parameter int NOC_W      = 64,
   parameter int AXI_DATA_W = 512,
   parameter int AXI_ID_W   = 4,
   parameter int AXI_RESP_W = 2
);
   logic                  noc_valid_in;
   logic [NOC_W-1:0]      noc_data_in;
   logic                  noc_ready_out;
   logic                  txn_valid_in;
   logic                  txn_ready_out;
   logic                  txn_is_store_in;
   logic [AXI_ID_W-1:0]   txn_id_in;
   logic [7:0]            txn_beats_in;
   logic [AXI_ID_W-1:0]   m_axi_rid;
   logic [AXI_DATA_W-1:0] m_axi_rdata;
   logic [AXI_RESP_W-1:0] m_axi_rresp;
   logic                  m_axi_rlast;
   logic                  m_axi_rvalid;
   logic                  m_axi_rready;
   logic [AXI_ID_W-1:0]   m_axi_bid;
   logic [AXI_RESP_W-1:0] m_axi_bresp;
   logic                  m_axi_bvalid;
   logic                  m_axi_bready;

   modport master (
      input  noc_valid_in, noc_data_in, txn_valid_in, txn_is_store_in, txn_id_in, txn_beats_in,
      input  m_axi_rready, m_axi_bready,
      output noc_ready_out, txn_ready_out,
      output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
      output m_axi_bid, m_axi_bresp, m_axi_bvalid
   );

   modport slave (
      output noc_valid_in, noc_data_in, txn_valid_in, txn_is_store_in, txn_id_in, txn_beats_in,
      output m_axi_rready, m_axi_bready,
      input  noc_ready_out, txn_ready_out,
      input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
      input  m_axi_bid, m_axi_bresp, m_axi_bvalid
   );
endinterface
`default_nettype wire

// File: rtl/noc_response_axi_mc.sv
`default_nettype none
// noc_response_axi_mc -- NoC response flits to AXI R/B channels with ID return, burst
// packing, length checking and sticky protocol error (rev 1.0)
module noc_response_axi_mc_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  wire          clk,
   input  wire          rst_n,
   input  wire          i_push,
   input  wire          i_pop,
   input  wire  [W-1:0] i_data,
   output logic [W-1:0] o_data,
   output logic         o_empty,
   output logic         o_full
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0]   r_cnt;
   logic          w_push, w_pop;

   assign o_empty = (r_cnt == '0);
   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_data  = r_mem[r_rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= (r_wptr == AW'(DEPTH-1)) ? '0 : r_wptr + 1'b1;
         end
         if (w_pop) r_rptr <= (r_rptr == AW'(DEPTH-1)) ? '0 : r_rptr + 1'b1;
         r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      end
   end
endmodule

module noc_response_axi_mc #(
   parameter int NOC_W      = 64,
   parameter int AXI_DATA_W = 512,
   parameter int AXI_ID_W   = 4,
   parameter int AXI_RESP_W = 2,
   parameter int TXN_DEPTH  = 8,
   parameter int R_DEPTH    = 4,
   parameter int B_DEPTH    = 4
) (
   input  wire                   clk,
   input  wire                   rst_n,
   noc_response_axi_mc_if.master bus,
   output logic                  err_o
);
   localparam int RATIO = AXI_DATA_W / NOC_W;
   localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int DW    = 1 + AXI_ID_W + 8;
   localparam int RW    = AXI_ID_W + AXI_DATA_W + AXI_RESP_W + 1;
   localparam int BW    = AXI_ID_W + AXI_RESP_W;
   localparam logic [7:0] MSG_TYPE_DATA_ACK        = 8'h01;
   localparam logic [7:0] MSG_TYPE_NODATA_ACK      = 8'h02;
   localparam logic [7:0] MSG_TYPE_NC_LOAD_MEM_ACK = 8'h03;
   localparam logic [7:0] MSG_TYPE_NC_STORE_MEM_ACK= 8'h04;
   localparam logic [AXI_RESP_W-1:0] RESP_OKAY     = '0;
   localparam logic [AXI_RESP_W-1:0] RESP_SLVERR   = AXI_RESP_W'(2);

   typedef enum logic [1:0] {S_HDR = 2'd0, S_LOAD = 2'd1, S_DROP = 2'd2} state_t;

   state_t                r_state, w_state_nxt;
   logic                  r_live, r_err;
   logic [AXI_ID_W-1:0]   r_id;
   logic [7:0]            r_beats, r_len, r_cnt, r_beat;
   logic [11:0]           r_exp;
   logic [LW-1:0]         r_lane;
   logic [AXI_DATA_W-1:0] r_pack, w_pack_nxt;
   logic [NOC_W-1:0]      w_flit_rev;

   logic [DW-1:0] w_desc;
   logic          w_desc_empty, w_desc_full, w_desc_pop;
   logic [RW-1:0] w_r_in, w_r_out;
   logic          w_r_push, w_r_empty, w_r_full;
   logic [BW-1:0] w_b_out;
   logic          w_b_push, w_b_empty, w_b_full;

   logic                  w_ready, w_fire, w_err_set, w_hdr_take;
   logic [AXI_ID_W-1:0]   w_r_id;
   logic [AXI_DATA_W-1:0] w_r_data;
   logic [AXI_RESP_W-1:0] w_r_resp;
   logic                  w_r_last;

   // Header fields: type in byte 0, length (flits following the header) in byte 1
   logic [7:0] w_type, w_len;
   assign w_type = bus.noc_data_in[7:0];
   assign w_len  = bus.noc_data_in[15:8];

   logic                w_head_store;
   logic [AXI_ID_W-1:0] w_head_id;
   logic [7:0]          w_head_beats;
   assign w_head_store = w_desc[DW-1];
   assign w_head_id    = w_desc[8 +: AXI_ID_W];
   assign w_head_beats = w_desc[7:0];

   logic w_load_ok, w_store_ok;
   assign w_load_ok  = !w_desc_empty && !w_head_store &&
                       (w_type == MSG_TYPE_DATA_ACK || w_type == MSG_TYPE_NC_LOAD_MEM_ACK);
   assign w_store_ok = !w_desc_empty && w_head_store &&
                       (w_type == MSG_TYPE_NODATA_ACK || w_type == MSG_TYPE_NC_STORE_MEM_ACK);

   logic w_final, w_in_range, w_short, w_long, w_exp_last, w_lane_last;
   assign w_final     = (r_cnt == r_len - 8'd1);
   assign w_in_range  = ({4'd0, r_cnt} < r_exp);
   assign w_short     = ({4'd0, r_len} < r_exp);
   assign w_long      = ({4'd0, r_len} > r_exp);
   assign w_exp_last  = ({4'd0, r_cnt} == r_exp - 12'd1);
   assign w_lane_last = (r_lane == LW'(RATIO-1));
   assign w_fire      = bus.noc_valid_in && w_ready;

   // A new beat starts from zero so a short final beat leaves its unused lanes cleared
   always_comb begin
      for (int b = 0; b < NOC_W/8; b++) w_flit_rev[b*8 +: 8] = bus.noc_data_in[NOC_W-8-b*8 +: 8];
      w_pack_nxt = (r_lane == '0) ? '0 : r_pack;
      w_pack_nxt[int'(r_lane)*NOC_W +: NOC_W] = w_flit_rev;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_desc_pop  = 1'b0;
      w_r_push    = 1'b0;
      w_b_push    = 1'b0;
      w_err_set   = 1'b0;
      w_hdr_take  = 1'b0;
      w_r_id      = r_id;
      w_r_data    = w_pack_nxt;
      w_r_resp    = RESP_OKAY;
      w_r_last    = 1'b0;
      case (r_state)
         S_HDR: begin
            if (w_store_ok)                    w_ready = r_live && !w_b_full;
            else if (w_load_ok && w_len == '0) w_ready = r_live && !w_r_full;
            else                               w_ready = r_live;
            if (w_fire) begin
               w_hdr_take = 1'b1;
               if (w_load_ok) begin
                  if (w_len == '0) begin
                     w_desc_pop = 1'b1;
                     w_r_push   = 1'b1;
                     w_r_id     = w_head_id;
                     w_r_data   = '0;
                     w_r_resp   = RESP_SLVERR;
                     w_r_last   = 1'b1;
                  end else begin
                     w_state_nxt = S_LOAD;
                  end
               end else if (w_store_ok) begin
                  w_desc_pop = 1'b1;
                  w_b_push   = 1'b1;
                  if (w_len != '0) w_state_nxt = S_DROP;
               end else begin
                  w_err_set = 1'b1;
                  if (w_len != '0) w_state_nxt = S_DROP;
               end
            end
         end
         S_LOAD: begin
            w_ready = r_live && !w_r_full;
            if (w_fire) begin
               if (w_in_range && (w_lane_last || w_final)) begin
                  w_r_push = 1'b1;
                  w_r_last = (r_beat == r_beats) || w_final;
                  if ((w_final && w_short) || (w_exp_last && w_long)) w_r_resp = RESP_SLVERR;
               end
               if (w_final) begin
                  w_desc_pop  = 1'b1;
                  w_state_nxt = S_HDR;
               end
            end
         end
         S_DROP: begin
            w_ready = r_live;
            if (w_fire && w_final) w_state_nxt = S_HDR;
         end
         default: w_state_nxt = S_HDR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_HDR;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live  <= 1'b0;
         r_err   <= 1'b0;
         r_id    <= '0;
         r_beats <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_beat  <= '0;
         r_exp   <= '0;
         r_lane  <= '0;
         r_pack  <= '0;
      end else begin
         r_live <= 1'b1;
         if (w_err_set) r_err <= 1'b1;
         if (w_hdr_take) begin
            r_id    <= w_head_id;
            r_beats <= w_head_beats;
            r_len   <= w_len;
            r_exp   <= 12'((int'(w_head_beats) + 1) * RATIO);
            r_cnt   <= '0;
            r_lane  <= '0;
            r_beat  <= '0;
         end else if (w_fire) begin
            r_cnt <= r_cnt + 8'd1;
            if (r_state == S_LOAD && w_in_range) begin
               r_pack <= w_pack_nxt;
               r_lane <= w_lane_last ? '0 : r_lane + 1'b1;
               if (w_lane_last) r_beat <= r_beat + 8'd1;
            end
         end
      end
   end

   assign w_r_in = {w_r_id, w_r_data, w_r_resp, w_r_last};

   noc_response_axi_mc_fifo #(.W(DW), .DEPTH(TXN_DEPTH)) u_desc_fifo (
      .clk(clk), .rst_n(rst_n), .i_push(bus.txn_valid_in), .i_pop(w_desc_pop),
      .i_data({bus.txn_is_store_in, bus.txn_id_in, bus.txn_beats_in}),
      .o_data(w_desc), .o_empty(w_desc_empty), .o_full(w_desc_full)
   );

   noc_response_axi_mc_fifo #(.W(RW), .DEPTH(R_DEPTH)) u_r_fifo (
      .clk(clk), .rst_n(rst_n), .i_push(w_r_push), .i_pop(bus.m_axi_rready),
      .i_data(w_r_in), .o_data(w_r_out), .o_empty(w_r_empty), .o_full(w_r_full)
   );

   noc_response_axi_mc_fifo #(.W(BW), .DEPTH(B_DEPTH)) u_b_fifo (
      .clk(clk), .rst_n(rst_n), .i_push(w_b_push), .i_pop(bus.m_axi_bready),
      .i_data({w_head_id, RESP_OKAY}), .o_data(w_b_out), .o_empty(w_b_empty), .o_full(w_b_full)
   );

   assign bus.noc_ready_out = w_ready;
   assign bus.txn_ready_out = !w_desc_full;
   assign {bus.m_axi_rid, bus.m_axi_rdata, bus.m_axi_rresp, bus.m_axi_rlast} = w_r_out;
   assign bus.m_axi_rvalid  = !w_r_empty;
   assign {bus.m_axi_bid, bus.m_axi_bresp} = w_b_out;
   assign bus.m_axi_bvalid  = !w_b_empty;
   assign err_o             = r_err;
endmodule
`default_nettype wire

// File: tb/tb_noc_response_axi_mc.sv
`default_nettype none
// tb_noc_response_axi_mc -- directed and randomized checks of the NoC-response-to-AXI converter
module tb_noc_response_axi_mc;
   localparam int NOC_W = 64, AXI_W = 128, ID_W = 4, RATIO = AXI_W / NOC_W;
   localparam int TXN_DEPTH = 4, R_DEPTH = 2, B_DEPTH = 1;
   localparam logic [7:0] T_DATA = 8'h01, T_NODATA = 8'h02, T_NCLOAD = 8'h03, T_NCSTORE = 8'h04;
   localparam logic [7:0] T_BAD = 8'h7E;

   typedef struct packed {logic [ID_W-1:0] id; logic [AXI_W-1:0] data; logic [1:0] resp; logic last;} rbeat_t;
   typedef struct packed {logic [ID_W-1:0] id; logic [1:0] resp;} bresp_t;
   typedef struct packed {logic st; logic [ID_W-1:0] id; logic [7:0] beats;} desc_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic err_o;
   always #5 clk = ~clk;

   noc_response_axi_mc_if #(.NOC_W(NOC_W), .AXI_DATA_W(AXI_W), .AXI_ID_W(ID_W), .AXI_RESP_W(2)) bus();

   noc_response_axi_mc #(
      .NOC_W(NOC_W), .AXI_DATA_W(AXI_W), .AXI_ID_W(ID_W), .AXI_RESP_W(2),
      .TXN_DEPTH(TXN_DEPTH), .R_DEPTH(R_DEPTH), .B_DEPTH(B_DEPTH)
   ) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master), .err_o(err_o));

   int checks = 0, errors = 0;
   int rmode = 0, bmode = 0;
   rbeat_t exp_r[$], obs_r[$];
   bresp_t exp_b[$], obs_b[$];
   desc_t  mdesc[$];
   bit     m_err = 1'b0;

   task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ready driver and handshake recorder; ready chosen on the falling edge
   initial begin
      rbeat_t r_cur, r_prev;
      bresp_t b_cur, b_prev;
      bit r_st = 0, b_st = 0;
      bus.m_axi_rready = 1'b0;
      bus.m_axi_bready = 1'b0;
      forever begin
         @(negedge clk);
         r_cur = {bus.m_axi_rid, bus.m_axi_rdata, bus.m_axi_rresp, bus.m_axi_rlast};
         b_cur = {bus.m_axi_bid, bus.m_axi_bresp};
         if (rst_n) begin
            if (r_st) check("r_hold", {bus.m_axi_rvalid, r_cur}, {1'b1, r_prev});
            if (b_st) check("b_hold", {bus.m_axi_bvalid, b_cur}, {1'b1, b_prev});
         end
         bus.m_axi_rready = (rmode == 1) ? 1'b0 : (rmode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
         bus.m_axi_bready = (bmode == 1) ? 1'b0 : (bmode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
         if (rst_n && bus.m_axi_rvalid && bus.m_axi_rready) obs_r.push_back(r_cur);
         if (rst_n && bus.m_axi_bvalid && bus.m_axi_bready) obs_b.push_back(b_cur);
         r_st = rst_n && bus.m_axi_rvalid && !bus.m_axi_rready;
         b_st = rst_n && bus.m_axi_bvalid && !bus.m_axi_bready;
         r_prev = r_cur;
         b_prev = b_cur;
      end
   end

   task automatic push_desc(bit st, logic [ID_W-1:0] id, logic [7:0] beats);
      int n = 0;
      logic rdy;
      desc_t d;
      bus.txn_valid_in = 1'b1;
      bus.txn_is_store_in = st;
      bus.txn_id_in = id;
      bus.txn_beats_in = beats;
      do begin
         @(negedge clk);
         rdy = bus.txn_ready_out;
         tick();
         n++;
      end while (!rdy && n < 200);
      check("txn_accept", rdy, 1);
      bus.txn_valid_in = 1'b0;
      d.st = st; d.id = id; d.beats = beats;
      mdesc.push_back(d);
   endtask

   task automatic send_flit(logic [63:0] f);
      int n = 0;
      logic rdy;
      bus.noc_valid_in = 1'b1;
      bus.noc_data_in = f;
      do begin
         @(negedge clk);
         rdy = bus.noc_ready_out;
         tick();
         n++;
      end while (!rdy && n < 200);
      check("noc_accept", rdy, 1);
      bus.noc_valid_in = 1'b0;
   endtask

   // Reference: what a response message should produce, given the descriptor queue head
   task automatic send_msg(logic [7:0] typ, logic [7:0] len);
      logic [63:0] flits[$];
      logic [63:0] f, rv;
      desc_t d;
      rbeat_t rb;
      bresp_t bb;
      int e, n, nb;
      bit lt, stt;
      for (int i = 0; i < int'(len); i++) flits.push_back({$urandom, $urandom});
      lt  = (typ == T_DATA) || (typ == T_NCLOAD);
      stt = (typ == T_NODATA) || (typ == T_NCSTORE);
      if (mdesc.size() != 0 && lt && !mdesc[0].st) begin
         d = mdesc.pop_front();
         e = (int'(d.beats) + 1) * RATIO;
         if (len == 8'd0) begin
            rb.id = d.id; rb.data = '0; rb.resp = 2'b10; rb.last = 1'b1;
            exp_r.push_back(rb);
         end else begin
            n  = (int'(len) < e) ? int'(len) : e;
            nb = (n + RATIO - 1) / RATIO;
            for (int b = 0; b < nb; b++) begin
               rb.id = d.id;
               rb.data = '0;
               for (int j = 0; j < RATIO; j++) begin
                  if (b*RATIO + j < n) begin
                     f = flits[b*RATIO + j];
                     rv = {<<8{f}};
                     rb.data[j*64 +: 64] = rv;
                  end
               end
               rb.resp = (b == nb-1 && int'(len) != e) ? 2'b10 : 2'b00;
               rb.last = (b == nb-1);
               exp_r.push_back(rb);
            end
         end
      end else if (mdesc.size() != 0 && stt && mdesc[0].st) begin
         d = mdesc.pop_front();
         bb.id = d.id; bb.resp = 2'b00;
         exp_b.push_back(bb);
      end else begin
         m_err = 1'b1;
      end
      send_flit({$urandom, 16'h0, len, typ});
      foreach (flits[i]) send_flit(flits[i]);
   endtask

   task automatic drain_compare(string tag);
      int n = 0;
      int m;
      while ((obs_r.size() < exp_r.size() || obs_b.size() < exp_b.size()) && n < 400) begin
         tick();
         n++;
      end
      repeat (4) tick();
      check({tag, "_rcount"}, obs_r.size(), exp_r.size());
      check({tag, "_bcount"}, obs_b.size(), exp_b.size());
      m = (obs_r.size() < exp_r.size()) ? obs_r.size() : exp_r.size();
      for (int i = 0; i < m; i++) check({tag, "_rbeat"}, obs_r[i], exp_r[i]);
      m = (obs_b.size() < exp_b.size()) ? obs_b.size() : exp_b.size();
      for (int i = 0; i < m; i++) check({tag, "_bresp"}, obs_b[i], exp_b[i]);
      obs_r.delete(); exp_r.delete(); obs_b.delete(); exp_b.delete();
   endtask

   initial begin
      logic [7:0] typ, len;
      desc_t d;
      bresp_t bb;
      bus.noc_valid_in = 1'b0; bus.noc_data_in = '0;
      bus.txn_valid_in = 1'b0; bus.txn_is_store_in = 1'b0; bus.txn_id_in = '0; bus.txn_beats_in = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_rvalid", bus.m_axi_rvalid, 0);
      check("rst_bvalid", bus.m_axi_bvalid, 0);
      check("rst_rlast", bus.m_axi_rlast, 0);
      check("rst_resp", {bus.m_axi_rresp, bus.m_axi_bresp}, 0);
      check("rst_err", err_o, 0);
      check("rst_noc_ready", bus.noc_ready_out, 0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // 4-beat load with stalling R, exact length
      push_desc(1'b0, 4'd5, 8'd3);
      send_msg(T_DATA, 8'd8);
      drain_compare("load4");

      // Short load: second beat zero-filled, SLVERR, last
      push_desc(1'b0, 4'd6, 8'd1);
      send_msg(T_NCLOAD, 8'd3);
      drain_compare("short");
      check("err_after_loads", err_o, 0);

      // Store ack held while bready low, visible the cycle after the header
      bmode = 1;
      push_desc(1'b1, 4'd7, 8'd0);
      send_msg(T_NODATA, 8'd0);
      check("store_bvalid", {bus.m_axi_bvalid, bus.m_axi_bid, bus.m_axi_bresp}, {1'b1, 4'd7, 2'b00});
      repeat (4) begin
         tick();
         check("store_bhold", {bus.m_axi_bvalid, bus.m_axi_bid}, {1'b1, 4'd7});
      end
      bmode = 2;
      drain_compare("store");

      // Single-entry B buffer back-pressures the second store header
      bmode = 1;
      push_desc(1'b1, 4'd1, 8'd0);
      push_desc(1'b1, 4'd2, 8'd0);
      send_msg(T_NCSTORE, 8'd0);
      bus.noc_data_in = {32'h0, 16'h0, 8'h0, T_NODATA};
      bus.noc_valid_in = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("bfull_stall", bus.noc_ready_out, 0);
      end
      d = mdesc.pop_front();
      bb.id = d.id; bb.resp = 2'b00;
      exp_b.push_back(bb);
      bmode = 2;
      send_flit({32'h0, 16'h0, 8'h0, T_NODATA});
      drain_compare("bstall");
      check("err_after_stores", err_o, 0);

      // Data ack with no descriptor: dropped, sticky error
      bmode = 0;
      send_msg(T_DATA, 8'd2);
      drain_compare("nodesc");
      check("err_set", err_o, 1);
      repeat (3) tick();
      check("err_sticky", err_o, 1);

      // Randomized mix of matching, mismatching and malformed responses
      for (int it = 0; it < 60; it++) begin
         if (mdesc.size() < TXN_DEPTH && $urandom_range(0, 3) != 0)
            push_desc(1'($urandom_range(0, 1)), ID_W'($urandom), 8'($urandom_range(0, 3)));
         if (mdesc.size() != 0 && $urandom_range(0, 9) < 7) begin
            if (mdesc[0].st) typ = ($urandom_range(0, 1) != 0) ? T_NODATA : T_NCSTORE;
            else             typ = ($urandom_range(0, 1) != 0) ? T_DATA : T_NCLOAD;
         end else begin
            case ($urandom_range(0, 4))
               0: typ = T_DATA;
               1: typ = T_NODATA;
               2: typ = T_NCLOAD;
               3: typ = T_NCSTORE;
               default: typ = T_BAD;
            endcase
         end
         if (mdesc.size() != 0 && !mdesc[0].st && (typ == T_DATA || typ == T_NCLOAD))
            len = 8'($urandom_range(0, (int'(mdesc[0].beats) + 1) * RATIO + 2));
         else
            len = 8'($urandom_range(0, 3));
         send_msg(typ, len);
         drain_compare("rnd");
         check("rnd_err", err_o, m_err);
      end

      // Asynchronous reset in the middle of a load burst
      @(negedge clk) rst_n = 1'b0;
      tick();
      @(negedge clk) rst_n = 1'b1;
      tick();
      mdesc.delete();
      rmode = 1;
      push_desc(1'b0, 4'd9, 8'd1);
      send_flit({32'h0, 16'h0, 8'd4, T_DATA});
      send_flit(64'h1111_2222_3333_4444);
      send_flit(64'h5555_6666_7777_8888);
      send_flit(64'h9999_AAAA_BBBB_CCCC);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rvalid", bus.m_axi_rvalid, 0);
      check("mid_rfields", {bus.m_axi_rlast, bus.m_axi_rresp, bus.m_axi_rid}, 0);
      check("mid_bvalid", bus.m_axi_bvalid, 0);
      check("mid_noc_ready", bus.noc_ready_out, 0);
      check("mid_err", err_o, 0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      mdesc.delete(); obs_r.delete(); exp_r.delete(); obs_b.delete(); exp_b.delete();
      m_err = 1'b0;
      rmode = 0;
      push_desc(1'b0, 4'd10, 8'd1);
      send_msg(T_NCLOAD, 8'd4);
      drain_compare("post_rst");
      check("post_rst_err", err_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/noc_response_axi_mc.md
Name: noc_response_axi_mc

Overview:
- Parametrised successor NoC-response-to-AXI converter. Sits between the NoC response channel (memory/L2 side) and the AXI master response channels (R, B) of the vector/accelerator port.
- Generalised over AXI/NoC width ratio, AXI ID, response-buffer depth and outstanding-transaction depth.
- Adds ID return, correct RLAST per burst, multi-beat store acks, SLVERR on length mismatch, and a sticky protocol-error flag.

Parameters:
- NOC_W, 64, NoC flit width; equals `NOC_DATA_WIDTH.
- AXI_DATA_W, 512, AXI data width; integer multiple of NOC_W (RATIO = AXI_DATA_W/NOC_W, 1..8).
- AXI_ID_W, 4, AXI ID width.
- AXI_RESP_W, 2, AXI response width.
- TXN_DEPTH, 8, outstanding-transaction FIFO depth (power of 2).
- R_DEPTH, 4, R-beat buffer depth (power of 2).
- B_DEPTH, 4, B-response buffer depth (power of 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- noc_valid_in  in  1  NoC flit valid
- noc_data_in  in  NOC_W  NoC flit; header fields at `MSG_TYPE and `MSG_LENGTH
- noc_ready_out  out  1  NoC flit accept
- txn_valid_in  in  1  request side pushes transaction descriptor
- txn_ready_out  out  1  descriptor FIFO not full
- txn_is_store_in  in  1  1 = store, 0 = load
- txn_id_in  in  AXI_ID_W  AXI ID of transaction
- txn_beats_in  in  8  AXI beats expected minus 1 (AXI LEN)
- m_axi_rid  out  AXI_ID_W  read ID
- m_axi_rdata  out  AXI_DATA_W  read data
- m_axi_rresp  out  AXI_RESP_W  read response
- m_axi_rlast  out  1  last beat of burst
- m_axi_rvalid  out  1  read valid
- m_axi_rready  in  1  read ready
- m_axi_bid  out  AXI_ID_W  write ID
- m_axi_bresp  out  AXI_RESP_W  write response
- m_axi_bvalid  out  1  write valid
- m_axi_bready  in  1  write ready
- err_o  out  1  sticky protocol error

Behaviour:
- Reset: all FIFOs empty; FSM in HDR; err_o=0; m_axi_rvalid=0, m_axi_bvalid=0, m_axi_rlast=0; rresp/bresp=0; noc_ready_out=0 until the first cycle after reset deassertion.
- A NoC flit transfers when noc_valid_in && noc_ready_out. A descriptor transfers when txn_valid_in && txn_ready_out.
- FSM states: HDR, LOAD, DROP.
- HDR:
  - noc_ready_out = 1 when the descriptor FIFO is non-empty, or when it is empty (to allow dropping).
  - On header accept, the message is matched against the descriptor FIFO head.
  - MSG_TYPE_DATA_ACK or NC_LOAD_MEM_ACK with head is_store=0 -> latch id, expected flits = (beats+1)*RATIO, received len = `MSG_LENGTH. Go to LOAD, or emit an error beat if len=0.
  - NODATA_ACK or NC_STORE_MEM_ACK with head is_store=1 -> push B entry {id, OKAY}; pop descriptor. Requires B FIFO not full, else noc_ready_out=0. If len>0, go to DROP.
  - Any other type, type/descriptor mismatch, or empty descriptor FIFO -> err_o set; no pop; len>0 -> DROP, else stay in HDR.
- LOAD:
  - Each accepted flit is byte-reversed per flit and placed in lane k of the packing register; k counts 0..RATIO-1.
  - When k wraps, or on the final flit: push an R entry {id, data, resp, last}. noc_ready_out = !R_full in LOAD.
  - last = 1 on beat index == beats.
  - If len < expected: on the final received flit, zero-fill the remaining lanes and push with last=1, resp=SLVERR (2'b10). Pop the descriptor; err_o is not set.
  - If len > expected: flits beyond expected are discarded; the last pushed beat carries resp=SLVERR.
  - On consuming len flits: pop descriptor, go to HDR.
- DROP: accept and discard the remaining len flits, then go to HDR. noc_ready_out=1.
- R/B outputs come straight from the FIFO heads. Valid = !empty; pop on valid&&ready. Data/ID/last/resp are held stable while valid && !ready.
- Latency: the last flit of a beat is accepted in cycle N; rvalid rises in cycle N+1. A store header is accepted in N; bvalid rises in N+1.
- Simultaneous push and pop on a full FIFO is not allowed: the push is gated by full.
- A descriptor push and pop in the same cycle are both honoured.
- Reset mid-burst discards all state, including partial packing.
- err_o clears only on reset.

Test Plan:
- RATIO=8, load id=3 beats=0, header len=8 plus 8 flits 0x01..0x08 -> one R beat: rid=3, rlast=1, rresp=0, lane 0 = byte-reversed 0x01.
- RATIO=2, load id=5 beats=3, len=8 with rready toggling 50% -> 4 beats, rlast only on the 4th, data stable while stalled, no flit lost.
- Store id=7 len=0 with bready=0 for 5 cycles -> bvalid high from the cycle after the header, bid=7, bresp=0, held until bready.
- Two store descriptors, B_DEPTH=1, bready=0 -> second header stalls (noc_ready_out=0) until first B handshake.
- Load beats=1 RATIO=2, len=3 -> 2 beats; 2nd has lanes[1] zero, rlast=1, rresp=2'b10.
- Data ack with empty descriptor FIFO, len=2 -> 3 flits consumed, no R/B output, err_o=1 persistent; rst_n low mid-LOAD -> all outputs 0 asynchronously.
